line_wr_buffer: RTL

//  Line-granular write-back buffer between the cache's main-memory port and main memory.

---
 rtl/line_wr_buffer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/line_wr_buffer.sv
// line_wr_buffer: line-granular write-back buffer between a cache's memory
// port and main memory. Dirty lines are absorbed in one cycle and drained in
// the background; reads hit in the buffer or bypass queued drains downstream.
module line_wr_buffer #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned DEPTH_LEN     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_LEN-1:0]                   up_addr,
  input  logic                                  up_rd_req,
  input  logic                                  up_wr_req,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      up_wr_line,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]      up_rd_line,
  output logic                                  up_gnt,
  output logic [ADDR_LEN-1:0]                   dn_addr,
  output logic                                  dn_rd_req,
  output logic                                  dn_wr_req,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]      dn_wr_line,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      dn_rd_line,
  input  logic                                  dn_gnt,
  output logic                                  empty,
  output logic                                  full
);

  localparam int unsigned LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int unsigned LINE_W    = 32 * LINE_SIZE;
  localparam int unsigned DEPTH     = 1 << DEPTH_LEN;

  typedef enum logic [1:0] {
    D_IDLE,
    D_READ,
    D_DRAIN
  } dstate_e;

  // Buffer storage and queue bookkeeping
  logic [ADDR_LEN-1:0]  addr_q [DEPTH];
  logic [LINE_W-1:0]    line_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH_LEN-1:0] head_q, head_d;
  logic [DEPTH_LEN-1:0] tail_q, tail_d;
  logic [DEPTH_LEN:0]   count_q, count_d;

  // Upstream side
  logic                 up_gnt_q;
  logic [LINE_W-1:0]    up_rd_line_q;
  logic                 rd_pend_q;
  logic [ADDR_LEN-1:0]  rd_addr_q;

  // Downstream side
  dstate_e              dstate_q;
  logic [ADDR_LEN-1:0]  dn_addr_q;
  logic                 dn_rd_req_q;
  logic                 dn_wr_req_q;
  logic [LINE_W-1:0]    dn_wr_line_q;

  // Decode of the current cycle
  logic                 hit;
  logic [DEPTH_LEN-1:0] hit_idx;
  logic                 sample;
  logic                 is_rd;
  logic                 head_locked;
  logic                 wr_ovw;
  logic                 wr_push;
  logic                 rd_hit;
  logic                 rd_miss;
  logic                 pop;
  logic                 rd_done;
  logic                 full_w;

  assign full_w = (count_q == (DEPTH_LEN+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign full   = full_w;

  // Associative lookup of the upstream address; valid addresses are unique
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == up_addr)) begin
        hit     = 1'b1;
        hit_idx = DEPTH_LEN'(i);
      end
    end
  end

  // Classify the upstream request and the downstream completions
  always_comb begin
    sample  = !up_gnt_q && !rd_pend_q && (up_rd_req || up_wr_req);
    is_rd   = up_rd_req;
    // The FSM snapshots the head on the D_IDLE -> D_DRAIN edge, so the head
    // is already off-limits to overwrites in an idle cycle with data queued.
    head_locked = (dstate_q == D_DRAIN) || ((dstate_q == D_IDLE) && (count_q != '0));
    wr_ovw  = sample && !is_rd && hit && !((hit_idx == head_q) && head_locked);
    wr_push = sample && !is_rd && !hit && !full_w;
    rd_hit  = sample && is_rd && hit;
    rd_miss = sample && is_rd && !hit;
    pop     = (dstate_q == D_DRAIN) && dn_gnt;
    rd_done = (dstate_q == D_READ) && dn_gnt;
  end

  // Next pointer and occupancy values
  always_comb begin
    head_d  = pop     ? head_q + 1'b1 : head_q;
    tail_d  = wr_push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({wr_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer entries: push at tail, overwrite on match, invalidate head on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        line_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      if (wr_push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= up_addr;
        line_q[tail_q]  <= up_wr_line;
      end
      if (wr_ovw) begin
        line_q[hit_idx] <= up_wr_line;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Upstream grant, read data return and read-miss tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_gnt_q     <= 1'b0;
      up_rd_line_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      up_gnt_q <= wr_push || wr_ovw || rd_hit || rd_done;
      if (rd_hit) begin
        up_rd_line_q <= line_q[hit_idx];
      end else if (rd_done) begin
        up_rd_line_q <= dn_rd_line;
      end
      if (rd_miss) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= up_addr;
      end else if (rd_done) begin
        rd_pend_q <= 1'b0;
      end
    end
  end

  // Downstream FSM: read misses first, otherwise drain the head entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate_q     <= D_IDLE;
      dn_addr_q    <= '0;
      dn_rd_req_q  <= 1'b0;
      dn_wr_req_q  <= 1'b0;
      dn_wr_line_q <= '0;
    end else begin
      case (dstate_q)
        D_IDLE: begin
          if (rd_pend_q) begin
            dstate_q    <= D_READ;
            dn_rd_req_q <= 1'b1;
            dn_addr_q   <= rd_addr_q;
          end else if (count_q != '0) begin
            dstate_q     <= D_DRAIN;
            dn_wr_req_q  <= 1'b1;
            dn_addr_q    <= addr_q[head_q];
            dn_wr_line_q <= line_q[head_q];
          end
        end
        D_READ: begin
          if (dn_gnt) begin
            dstate_q    <= D_IDLE;
            dn_rd_req_q <= 1'b0;
          end
        end
        D_DRAIN: begin
          if (dn_gnt) begin
            dstate_q    <= D_IDLE;
            dn_wr_req_q <= 1'b0;
          end
        end
        default: begin
          dstate_q    <= D_IDLE;
          dn_rd_req_q <= 1'b0;
          dn_wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign up_gnt     = up_gnt_q;
  assign up_rd_line = up_rd_line_q;
  assign dn_addr    = dn_addr_q;
  assign dn_rd_req  = dn_rd_req_q;
  assign dn_wr_req  = dn_wr_req_q;
  assign dn_wr_line = dn_wr_line_q;

endmodule
